// File: rtl/nibble_serial_add_pkg.sv
// Shared definitions for the nibble-serial adder: sequencer state encoding and nibble width.
package nibble_serial_add_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Index counter width for a given nibble count; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_add_nibble_add.sv
// Purely combinational 4-bit ripple adder with carry-in and carry-out.
module nibble_add
  import nibble_serial_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                ci_i,
  output logic [NIBBLE_W-1:0] s_o,
  output logic                co_o
);

  logic [NIBBLE_W:0] c;

  // Ripple the carry bit by bit through the nibble.
  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = ci_i;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]  = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    co_o = c[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_add.sv
// WIDTH-bit adder built by time-sharing one 4-bit adder, least-significant nibble first.
// Optional feature: define SUBTRACT_EN to add a 'sub' input that turns the operation into a - b.
module nibble_serial_add
  import nibble_serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned IdxW    = idx_width(NIBBLES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  state_e            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  sum_q;
  logic [IdxW-1:0]   idx_q;
  logic              carry_q;
  logic              c_out_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;

  logic [WIDTH-1:0]    b_cap;
  logic                carry_cap;
  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] s_nib;
  logic                co_nib;

  // Operand conditioning at capture: subtraction is a + ~b + 1.
  always_comb begin
    b_cap     = b;
    carry_cap = c_in;
`ifdef SUBTRACT_EN
    if (sub) begin
      b_cap     = ~b;
      carry_cap = 1'b1;
    end
`endif
  end

  // Select the operand nibbles for the current pass.
  always_comb begin
    a_nib = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    b_nib = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
  end

  nibble_add u_nibble_add (
    .a_i  (a_nib),
    .b_i  (b_nib),
    .ci_i (carry_q),
    .s_o  (s_nib),
    .co_o (co_nib)
  );

  // Sequencer: capture operands, run one nibble per cycle, pulse done; outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b_cap;
            carry_q <= carry_cap;
            idx_q   <= '0;
            state_q <= StRun;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          sum_q[idx_q*NIBBLE_W +: NIBBLE_W] <= s_nib;
          carry_q <= co_nib;
          if (idx_q == LastIdx) begin
            // Final carry goes straight to the held output so it is valid with done.
            c_out_q <= co_nib;
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_nibble_serial_add.sv
// Self-checking bench for nibble_serial_add (WIDTH=16): vector table, corner sequences, random ops.
module tb_nibble_serial_add;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nibble_serial_add #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
`ifdef SUBTRACT_EN
    .sub   (sub),
`endif
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the whole operands.
  task automatic model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                       input logic isub, output logic [W-1:0] s, output logic co);
    logic [W:0] full;
    if (isub) begin
      s  = ia - ib;
      co = (ia >= ib);
    end else begin
      full = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, icin};
      s    = full[W-1:0];
      co   = full[W];
    end
  endtask

  // Issue one operation from idle and return the result, the start-to-done latency, and
  // check the done pulse width and the return to ready.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                       input logic isub, output logic [W-1:0] osum, output logic ocout,
                       output int lat);
    a = ia; b = ib; c_in = icin; sub = isub; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    osum  = sum;
    ocout = c_out;
    tick();
    check("done_single_cycle", {31'd0, done}, 32'd0);
    check("ready_after_done", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    logic [W-1:0] rs, es;
    logic         rc, ec;
    int           lat;
    logic         saw_done;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_busy",  {31'd0, busy},  32'd0);
    check("reset_done",  {31'd0, done},  32'd0);
    check("reset_sum",   {16'd0, sum},   32'd0);
    check("reset_cout",  {31'd0, c_out}, 32'd0);

    // Directed vectors with hand-computed results.
    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1});
    vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0});
`ifdef SUBTRACT_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
    vecs.push_back('{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1});
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, rs, rc, lat);
      check($sformatf("vec%0d_latency", i), lat, 32'd5);
      check($sformatf("vec%0d_sum", i), {16'd0, rs}, {16'd0, vecs[i].exp_sum});
      check($sformatf("vec%0d_cout", i), {31'd0, rc}, {31'd0, vecs[i].exp_cout});
    end

    // start re-asserted during RUN is ignored.
    a = 16'h00F0; b = 16'h0010; c_in = 1'b0; sub = 1'b0; start = 1'b1;
    tick();
    a = 16'h1111; b = 16'h1111; c_in = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      check($sformatf("busy_start_ready_c%0d", cyc), {31'd0, ready}, 32'd0);
      if (cyc == 5) begin
        check("busy_start_done", {31'd0, done}, 32'd1);
        check("busy_start_sum", {16'd0, sum}, 32'h0000_0100);
        check("busy_start_cout", {31'd0, c_out}, 32'd0);
        start = 1'b0;
      end
      tick();
    end
    check("busy_start_ready_c6", {31'd0, ready}, 32'd1);
    tick();
    check("busy_start_no_second_op", {31'd0, busy}, 32'd0);

    // Reset in cycle 3 of an operation aborts it.
    a = 16'h1234; b = 16'h1111; c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_busy",  {31'd0, busy},  32'd0);
    check("abort_done",  {31'd0, done},  32'd0);
    check("abort_sum",   {16'd0, sum},   32'd0);
    check("abort_cout",  {31'd0, c_out}, 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      saw_done |= done;
      tick();
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);
    do_op(16'h0F00, 16'h0100, 1'b1, 1'b0, rs, rc, lat);
    check("after_abort_latency", lat, 32'd5);
    check("after_abort_sum", {16'd0, rs}, 32'h0000_1001);

    // rst and start together: reset wins.
    rst = 1'b1; start = 1'b1; a = 16'hAAAA; b = 16'h5555;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_start_ready", {31'd0, ready}, 32'd1);
    check("rst_start_busy",  {31'd0, busy},  32'd0);
    check("rst_start_sum",   {16'd0, sum},   32'd0);

    // Randomised operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic         rcin, rsub;
      ra   = W'($urandom);
      rb   = W'($urandom);
      rcin = 1'($urandom_range(0, 1));
`ifdef SUBTRACT_EN
      rsub = 1'($urandom_range(0, 1));
`else
      rsub = 1'b0;
`endif
      if (i % 8 == 0) ra = 16'hFFFF;
      model(ra, rb, rcin, rsub, es, ec);
      do_op(ra, rb, rcin, rsub, rs, rc, lat);
      check($sformatf("rand%0d_latency", i), lat, 32'd5);
      check($sformatf("rand%0d_sum", i), {16'd0, rs}, {16'd0, es});
      check($sformatf("rand%0d_cout", i), {31'd0, rc}, {31'd0, ec});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add.md
# nibble_serial_add

Sequencer that performs WIDTH-bit addition by time-sharing a single 4-bit ripple adder across the operand, one nibble per clock, least-significant nibble first. The nibble carry-out is held in a register and fed back as the next nibble's carry-in. The block sits between a requesting datapath and the shared 4-bit adder, trading latency for area. It exposes a start/done handshake.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4
- NIBBLES, WIDTH/4, derived; number of adder passes per operation

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; sampled only when ready=1
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- c_in  input  1  initial carry-in; captured on accepted start
- ready  output  1  high in IDLE only
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse; sum and c_out valid
- sum  output  WIDTH  result; held until next accepted start
- c_out  output  1  final carry-out; held with sum

## Operation
- States: IDLE, RUN, DONE.
- IDLE: ready=1.
  - start=1 captures a, b, c_in into the operand registers.
  - Clears the nibble index to 0 and the carry register to c_in.
  - Moves to RUN.
- RUN: busy=1.
  - The 4-bit adder computes a_reg[4i+3:4i] + b_reg[4i+3:4i] + carry_reg.
  - At the clock edge, the result nibble is written to sum[4i+3:4i] and the carry register takes the nibble carry-out.
  - The index then increments.
  - When index = NIBBLES-1 at the edge, the machine moves to DONE instead of incrementing.
- DONE: done=1 for exactly one cycle; c_out = carry_reg. The machine returns to IDLE.
- start while RUN or DONE: ignored, with no effect on state or operands. The requester must wait for ready.
- sum bits are overwritten nibble by nibble during RUN. sum is valid only from the done cycle until the next accepted start.
- Arithmetic: unsigned modulo 2^WIDTH. c_out is the true carry out of bit WIDTH-1.
- The index counter is ceil(log2(NIBBLES)) bits wide, minimum 1. It never wraps past NIBBLES-1.

## Timing
- Reset values: state=IDLE, ready=1, busy=0, done=0, sum=0, c_out=0, index=0, carry_reg=0, operand registers=0.
- start is sampled high in cycle 0.
  - RUN occupies cycles 1..NIBBLES.
  - done=1 in cycle NIBBLES+1.
  - ready=1 again in cycle NIBBLES+2.
- Latency from start to done is NIBBLES+1 cycles; 5 for WIDTH=16.
- Throughput is one operation per NIBBLES+2 cycles.
- rst=1 in any state, including mid-RUN, returns all registers to reset values at that edge. The partial result is discarded, and no done is issued for the aborted operation.
- rst and start high in the same cycle: reset wins and start is dropped.
- The carry chain inside one cycle is only the 4-bit ripple path. There is no combinational path from inputs to outputs.

## Configuration
- SUBTRACT_EN defined:
  - Adds input port sub (1 bit), captured with the operands.
  - When sub=1, b is captured inverted and the initial carry is forced to 1, ignoring c_in.
  - Result is a - b mod 2^WIDTH. c_out=1 means no borrow (a >= b unsigned).
- SUBTRACT_EN undefined: no sub port; addition only, exactly as above.

## Structure
- Shared package holds:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - the NIBBLE_W=4 constant
- One sub-module, nibble_add: a purely combinational 4-bit add with carry-in and carry-out.
  - Instantiated once.
  - The sequencer muxes operand nibbles into it by index.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, c_in=0 -> sum=0x5555, c_out=0, done exactly 5 cycles after start, single-cycle pulse.
- a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1; the carry propagates through all four nibbles.
- a=0xFFFF, b=0x0000, c_in=1 -> sum=0x0000, c_out=1. Then a=0x0000, b=0x0000, c_in=0 -> sum=0x0000, c_out=0 (no stale carry).
- start re-asserted with a=0x1111, b=0x1111 during RUN of 0x00F0+0x0010 -> result 0x0100 unaffected, the second start ignored, ready low until cycle 6.
- rst asserted in cycle 3 of an operation -> all outputs at reset values the next cycle, no done pulse, the next start completes normally.
- SUBTRACT_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, c_out=0. a=0x0007, b=0x0005, sub=1 -> sum=0x0002, c_out=1.
